// File: rtl/fetch_unit.sv
// Instruction fetch stage: steers the enable-less ProgramCounter, issues one
// instruction-memory request at a time and loads the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    output logic [31:0] Address,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PCPlus4,
    output logic        IF_Valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        kill_reg, kill_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;
    logic [31:0] skid_reg, skid_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pcp4_reg, pcp4_next;
    logic        valid_reg, valid_next;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Branch wins over jump; targets are always word aligned.
    assign redirect   = BranchTaken | Jump;
    assign target_raw = BranchTaken ? BranchTarget : JumpTarget;
    assign target     = {target_raw[31:2], 2'b00};
    assign pc_plus4   = PCResult + 32'd4;

    always_comb begin
        state_next       = state_reg;
        kill_next        = kill_reg;
        redirect_pc_next = redirect_pc_reg;
        skid_next        = skid_reg;
        instr_next       = instr_reg;
        pcp4_next        = pcp4_reg;
        // IF/ID holds under stall, otherwise bubbles; a redirect always flushes.
        valid_next       = (Stall && !redirect) ? valid_reg : 1'b0;
        Address          = PCResult;
        ImemReq          = 1'b0;
        ImemAddr         = PCResult;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                ImemReq = 1'b1;
                if (!ImemReady) begin
                    if (redirect) begin
                        kill_next        = 1'b1;
                        redirect_pc_next = target;
                    end
                end else if (kill_reg || redirect) begin
                    Address    = redirect ? target : redirect_pc_reg;
                    kill_next  = 1'b0;
                    valid_next = 1'b0;
                end else if (!Stall) begin
                    instr_next = ImemData;
                    pcp4_next  = pc_plus4;
                    valid_next = 1'b1;
                    Address    = pc_plus4;
                end else begin
                    skid_next  = ImemData;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    Address    = target;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (!Stall) begin
                    instr_next = skid_reg;
                    pcp4_next  = pc_plus4;
                    valid_next = 1'b1;
                    Address    = pc_plus4;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset overrides the PC steering and abandons any open request.
        if (Reset) begin
            Address = RESET_PC;
            ImemReq = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg       <= IDLE;
            kill_reg        <= 1'b0;
            redirect_pc_reg <= 32'd0;
            skid_reg        <= 32'd0;
            instr_reg       <= 32'd0;
            pcp4_reg        <= 32'd0;
            valid_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            kill_reg        <= kill_next;
            redirect_pc_reg <= redirect_pc_next;
            skid_reg        <= skid_next;
            instr_reg       <= instr_next;
            pcp4_reg        <= pcp4_next;
            valid_reg       <= valid_next;
        end
    end

    assign IF_Instruction = instr_reg;
    assign IF_PCPlus4     = pcp4_reg;
    assign IF_Valid       = valid_reg;

endmodule
